// File: rtl/hack_memory_bus_pkg.sv
// ============================================================================
// Module      : hack_mem_pkg
// Description : Shared memory-map constants and scanner state for the Hack
//               data-memory responder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package hack_mem_pkg;

    localparam logic [14:0] SCREEN_BASE   = 15'h4000;
    localparam logic [14:0] KBD_ADDR      = 15'h6000;
    localparam int          WORDS_PER_ROW = 32;
    localparam int          SCREEN_ROWS   = 256;
    localparam int          SCAN_AW       = 13;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_SHIFT = 1'b1
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/hack_memory_bus_scanner.sv
// ============================================================================
// Module      : screen_scanner
// Description : Walks the screen buffer word by word and presents one pixel per
//               valid/ready transfer, with raster coordinates.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module screen_scanner
    import hack_mem_pkg::*;
#(
    parameter int SCREEN_WORDS = 8192
) (
    input  logic               clk,
    input  logic               rst,
    output logic [SCAN_AW-1:0] o_rd_addr,
    input  logic [15:0]        i_rd_data,
    output logic               o_pix_valid,
    input  logic               i_pix_ready,
    output logic               o_pix_data,
    output logic [8:0]         o_pix_x,
    output logic [7:0]         o_pix_y,
    output logic               o_frame_start
);

    localparam logic [SCAN_AW-1:0] c_LAST_WORD = SCAN_AW'(SCREEN_WORDS - 1);

    scan_state_t        r_state;
    scan_state_t        w_state_nxt;
    logic [15:0]        r_shreg;
    logic [3:0]         r_bit_idx;
    logic [SCAN_AW-1:0] r_scan_word;
    logic               w_xfer;

    assign w_xfer    = (r_state == ST_SHIFT) && i_pix_ready;
    assign o_rd_addr = r_scan_word;

    always_comb begin
        w_state_nxt   = r_state;
        o_pix_valid   = 1'b0;
        o_pix_data    = 1'b0;
        o_frame_start = 1'b0;
        o_pix_x       = {r_scan_word[4:0], r_bit_idx};
        o_pix_y       = r_scan_word[12:5];
        case (r_state)
            ST_FETCH: begin
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                o_pix_valid   = 1'b1;
                o_pix_data    = r_shreg[0];
                o_frame_start = (r_scan_word == '0) && (r_bit_idx == 4'd0);
                if (w_xfer && (r_bit_idx == 4'd15)) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // The shift register is the synchronous read register of the screen port;
    // a same-edge CPU write lands after this sample, so the old word is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FETCH;
            r_shreg     <= 16'h0000;
            r_bit_idx   <= 4'd0;
            r_scan_word <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_FETCH) begin
                r_shreg   <= i_rd_data;
                r_bit_idx <= 4'd0;
            end else if (w_xfer) begin
                r_shreg   <= {1'b0, r_shreg[15:1]};
                r_bit_idx <= r_bit_idx + 4'd1;
                if (r_bit_idx == 4'd15) begin
                    r_scan_word <= (r_scan_word == c_LAST_WORD) ? '0 : r_scan_word + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hack_memory_bus.sv
// ============================================================================
// Module      : hack_memory_bus
// Description : Hack CPU data memory: RAM, screen buffer and keyboard register
//               with zero-latency reads, plus a streaming screen scanner.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hack_memory_bus #(
    parameter int          RAM_WORDS    = 16384,
    parameter int          SCREEN_WORDS = 8192,
    parameter logic [14:0] KBD_ADDR     = 15'h6000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    output logic [15:0] inM,
    input  logic [15:0] kbd_code,
    input  logic        kbd_valid,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_data,
    output logic [8:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic        frame_start
);

    localparam int RA = $clog2(RAM_WORDS);
    localparam int SA = $clog2(SCREEN_WORDS);

    logic [15:0] r_ram    [RAM_WORDS];
    logic [15:0] r_screen [SCREEN_WORDS];
    logic [15:0] r_kbd;

    logic [14:0] w_scr_off;
    logic        w_is_ram;
    logic        w_is_scr;
    logic        w_is_kbd;
    logic [hack_mem_pkg::SCAN_AW-1:0] w_scan_addr;
    logic [15:0] w_scan_data;

    assign w_scr_off = addressM - hack_mem_pkg::SCREEN_BASE;
    assign w_is_ram  = addressM < 15'(RAM_WORDS);
    assign w_is_scr  = (addressM >= hack_mem_pkg::SCREEN_BASE) && (w_scr_off < 15'(SCREEN_WORDS));
    assign w_is_kbd  = addressM == KBD_ADDR;

    always_comb begin
        inM = 16'h0000;
        if (w_is_ram) begin
            inM = r_ram[addressM[RA-1:0]];
        end else if (w_is_scr) begin
            inM = r_screen[w_scr_off[SA-1:0]];
        end else if (w_is_kbd) begin
            inM = r_kbd;
        end
    end

    // Memory contents deliberately survive reset; only the keyboard latch clears.
    always_ff @(posedge clk) begin
        if (writeM && w_is_ram) begin
            r_ram[addressM[RA-1:0]] <= outM;
        end
        if (writeM && w_is_scr) begin
            r_screen[w_scr_off[SA-1:0]] <= outM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_kbd <= 16'h0000;
        end else if (kbd_valid) begin
            r_kbd <= kbd_code;
        end
    end

    assign w_scan_data = r_screen[w_scan_addr[SA-1:0]];

    screen_scanner #(
        .SCREEN_WORDS (SCREEN_WORDS)
    ) u_scanner (
        .clk           (clk),
        .rst           (reset),
        .o_rd_addr     (w_scan_addr),
        .i_rd_data     (w_scan_data),
        .o_pix_valid   (pix_valid),
        .i_pix_ready   (pix_ready),
        .o_pix_data    (pix_data),
        .o_pix_x       (pix_x),
        .o_pix_y       (pix_y),
        .o_frame_start (frame_start)
    );

endmodule

`default_nettype wire

// File: tb/tb_hack_memory_bus.sv
// ============================================================================
// Module      : tb_hack_memory_bus
// Description : Self-checking bench for hack_memory_bus (reduced screen depth
//               so a full frame fits in a short run).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_hack_memory_bus;

    localparam int SCR_WORDS  = 1024;
    localparam int FRAME_CYC  = SCR_WORDS * 17;
    localparam int LAST_Y     = SCR_WORDS / 32 - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic [15:0] kbd_code;
    logic        kbd_valid;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_data;
    logic [8:0]  pix_x;
    logic [7:0]  pix_y;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hack_memory_bus #(
        .RAM_WORDS    (16384),
        .SCREEN_WORDS (SCR_WORDS),
        .KBD_ADDR     (15'h6000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addressM    (addressM),
        .outM        (outM),
        .writeM      (writeM),
        .inM         (inM),
        .kbd_code    (kbd_code),
        .kbd_valid   (kbd_valid),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start)
    );

    typedef struct {
        logic [14:0] addr;
        logic [15:0] wdata;
        logic        we;
        logic [15:0] kc;
        logic        kv;
        logic        chk;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic take_pixel(input logic d, input int x, input int y, input logic fs, input string nm);
        int n;
        n = 0;
        pix_ready = 1'b1;
        while (!pix_valid && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_valid"}, 32'(pix_valid), 32'd1);
        chk({nm, "_data"},  32'(pix_data), 32'(d));
        chk({nm, "_x"},     32'(pix_x), 32'(x));
        chk({nm, "_y"},     32'(pix_y), 32'(y));
        chk({nm, "_fs"},    32'(frame_start), 32'(fs));
        tick();
    endtask

    initial begin
        logic [15:0] w1;
        logic [15:0] w2;
        int t_last;
        int t_fs1;
        int t_fs2;
        int n;

        w1 = 16'hA5C3;
        w2 = 16'h0F0F;

        vecs[0]  = '{15'h0006, 16'h5A5A, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{15'h0005, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[2]  = '{15'h0005, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234};
        vecs[3]  = '{15'h0006, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h5A5A};
        vecs[4]  = '{15'h6000, 16'h0000, 1'b0, 16'd65,   1'b1, 1'b1, 16'h0000};
        vecs[5]  = '{15'h6000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'd65};
        vecs[6]  = '{15'h6000, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1, 16'd65};
        vecs[7]  = '{15'h6000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'd65};
        vecs[8]  = '{15'h6001, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};
        vecs[9]  = '{15'h4005, 16'hABCD, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[10] = '{15'h4005, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hABCD};
        vecs[11] = '{15'h7000, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0000};
        vecs[12] = '{15'h7000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};
        vecs[13] = '{15'h4000, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[14] = '{15'h4000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF};

        reset = 1'b1; addressM = 15'h0000; outM = 16'h0000; writeM = 1'b0;
        kbd_code = 16'h0000; kbd_valid = 1'b0; pix_ready = 1'b0;

        // Preload the first screen words while the block is held in reset.
        addressM = 15'h4000; outM = 16'h0001; writeM = 1'b1; tick();
        addressM = 15'h4001; outM = w1;       tick();
        addressM = 15'h4002; outM = w2;       tick();
        writeM = 1'b0; addressM = 15'h6000; #1;
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_data",  32'(pix_data), 32'd0);
        chk("rst_x",     32'(pix_x), 32'd0);
        chk("rst_y",     32'(pix_y), 32'd0);
        chk("rst_fs",    32'(frame_start), 32'd0);
        chk("rst_kbd",   32'(inM), 32'd0);

        reset = 1'b0;
        tick();
        chk("first_valid", 32'(pix_valid), 32'd1);
        chk("first_fs",    32'(frame_start), 32'd1);
        chk("first_data",  32'(pix_data), 32'd1);

        for (int i = 0; i < 15; i++) begin
            addressM  = vecs[i].addr;
            outM      = vecs[i].wdata;
            writeM    = vecs[i].we;
            kbd_code  = vecs[i].kc;
            kbd_valid = vecs[i].kv;
            #1;
            if (vecs[i].chk) chk($sformatf("vec%0d_inM", i), 32'(inM), 32'(vecs[i].exp));
            tick();
        end
        writeM = 1'b0; kbd_valid = 1'b0;

        for (int i = 0; i < 16; i++)
            take_pixel((i == 0) ? 1'b1 : 1'b0, i, 0, (i == 0) ? 1'b1 : 1'b0, $sformatf("w0b%0d", i));
        for (int i = 0; i < 5; i++)
            take_pixel(w1[i], 16 + i, 0, 1'b0, $sformatf("w1b%0d", i));

        pix_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("stall%0d_valid", k), 32'(pix_valid), 32'd1);
            chk($sformatf("stall%0d_data", k),  32'(pix_data), 32'(w1[5]));
            chk($sformatf("stall%0d_x", k),     32'(pix_x), 32'd21);
            chk($sformatf("stall%0d_y", k),     32'(pix_y), 32'd0);
        end
        for (int i = 5; i < 16; i++)
            take_pixel(w1[i], 16 + i, 0, 1'b0, $sformatf("w1b%0d", i));

        // Now in the FETCH cycle of word 2: overwrite it on the fetch edge.
        chk("fetch_valid", 32'(pix_valid), 32'd0);
        addressM = 15'h4002; outM = 16'hFFFF; writeM = 1'b1;
        tick();
        writeM = 1'b0;
        for (int i = 0; i < 16; i++)
            take_pixel(w2[i], 32 + i, 0, 1'b0, $sformatf("w2b%0d", i));
        addressM = 15'h4002; #1;
        chk("coll_inM", 32'(inM), 32'hFFFF);

        t_last = -1; t_fs1 = -1; t_fs2 = -1;
        pix_ready = 1'b1;
        for (int c = 0; c < 40000 && t_fs2 < 0; c++) begin
            if (pix_valid && pix_x == 9'd511 && pix_y == 8'(LAST_Y) && t_fs1 < 0) t_last = c;
            if (frame_start) begin
                if (t_fs1 < 0) t_fs1 = c;
                else           t_fs2 = c;
            end
            tick();
        end
        chk("last_pix_seen", 32'(t_last >= 0), 32'd1);
        chk("fs_after_last", 32'(t_fs1 - t_last), 32'd2);
        chk("frame_period",  32'(t_fs2 - t_fs1), 32'(FRAME_CYC));

        n = 0;
        while (!(pix_valid && pix_y == 8'd20) && n < 20000) begin
            tick();
            n++;
        end
        chk("reach_y20", 32'(pix_y), 32'd20);
        reset = 1'b1;
        tick();
        chk("mrst_valid", 32'(pix_valid), 32'd0);
        chk("mrst_x",     32'(pix_x), 32'd0);
        chk("mrst_y",     32'(pix_y), 32'd0);
        reset = 1'b0;
        tick();
        chk("mrst_first_valid", 32'(pix_valid), 32'd1);
        chk("mrst_first_fs",    32'(frame_start), 32'd1);
        chk("mrst_first_x",     32'(pix_x), 32'd0);
        chk("mrst_first_y",     32'(pix_y), 32'd0);
        chk("mrst_first_data",  32'(pix_data), 32'd1);
        addressM = 15'h6000; #1;
        chk("mrst_kbd", 32'(inM), 32'd0);
        addressM = 15'h0005; #1;
        chk("mrst_ram5", 32'(inM), 32'h1234);
        addressM = 15'h0006; #1;
        chk("mrst_ram6", 32'(inM), 32'h5A5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
